// File: rtl/mobius_pkg.sv
// Shared types and helpers for the iterative GF(2) Mobius (ANF) transform engine.
package mobius_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of clocked steps needed to apply all LOG2_N layers.
    function automatic int mobius_steps(input int log2_n, input int lpc);
        return log2_n / lpc;
    endfunction

endpackage

// File: rtl/mobius_if.sv
// Valid/ready stream bundle between a table source/sink and the Mobius engine.
// out_zero exists only when MOBIUS_ZERO_FLAG_EN is defined.
interface mobius_if #(
    parameter int LOG2_N = 11
);
    localparam int N = 1 << LOG2_N;

    logic         in_valid;
    logic         in_ready;
    logic [0:N-1] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [0:N-1] out_data;
`ifdef MOBIUS_ZERO_FLAG_EN
    logic         out_zero;
`endif

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
`ifdef MOBIUS_ZERO_FLAG_EN
        input  out_zero,
`endif
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
`ifdef MOBIUS_ZERO_FLAG_EN
        output out_zero,
`endif
        output out_data
    );

endinterface

// File: rtl/mobius_round.sv
// One combinational Mobius layer: butterfly on the top index bit, then perfect shuffle
// so the next index bit becomes the top one.
module mobius_round #(
    parameter int LOG2_N = 11
) (
    input  logic [0:(1<<LOG2_N)-1] x_i,
    output logic [0:(1<<LOG2_N)-1] y_o
);
    localparam int N = 1 << LOG2_N;
    localparam int H = N / 2;

    // Lower half passes through, upper half absorbs its partner; outputs interleave.
    for (genvar i = 0; i < H; i++) begin : g_bfly
        assign y_o[2*i]   = x_i[i];
        assign y_o[2*i+1] = x_i[i+H] ^ x_i[i];
    end

endmodule

// File: rtl/mobius_engine.sv
// Iterative Mobius transform engine: LPC layers per clock, IDLE/RUN/DONE handshake FSM.
// Optional out_zero result flag enabled by MOBIUS_ZERO_FLAG_EN.
module mobius_engine
    import mobius_pkg::*;
#(
    parameter int LOG2_N = 11,
    parameter int LPC    = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    mobius_if.slave bus
);
    localparam int N     = 1 << LOG2_N;
    localparam int STEPS = mobius_steps(LOG2_N, LPC);
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (LPC < 1 || LPC > LOG2_N || (LOG2_N % LPC) != 0) begin : g_bad_lpc
        $error("mobius_engine: LPC must be in 1..LOG2_N and divide LOG2_N");
    end

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [0:N-1]     data_q;
    logic [0:N-1]     data_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [0:N-1]     stage_s [0:LPC];

    assign stage_s[0] = data_q;

    for (genvar k = 0; k < LPC; k++) begin : g_chain
        mobius_round #(.LOG2_N(LOG2_N)) u_round (
            .x_i (stage_s[k]),
            .y_o (stage_s[k+1])
        );
    end

    assign data_d = stage_s[LPC];

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_q;

`ifdef MOBIUS_ZERO_FLAG_EN
    logic out_zero_q;

    assign bus.out_zero = out_zero_q;

    // Zero flag is sampled from the same value that lands in data_q on the final step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_zero_q <= 1'b0;
        end else if (state_q == RUN && cnt_q == LAST_CNT) begin
            out_zero_q <= (data_d == '0);
        end else begin
            out_zero_q <= out_zero_q;
        end
    end
`endif

    // Control FSM, layer counter and data register with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_q     <= bus.in_data;
                        cnt_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    data_q <= data_d;
                    cnt_q  <= cnt_q + CNT_ONE;
                    if (cnt_q == LAST_CNT) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
